// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: packet layout, state encoding, opcodes and slot sizing.
// FETCH_STATIC_PREDICT_EN selects static prediction in fetch_stage; the types are common to both builds.
`ifndef N
`define N 2
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

package fetch_stage_pkg;

  localparam int unsigned NumSlots   = `N;
  localparam int unsigned ScalarBits = `NUM_SCALAR_BITS;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        pred_taken;
  } FETCH_PACKET;

  typedef enum logic [1:0] {REQ, WAIT, STREAM, DROP} fetch_state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Static predecode for one fetch slot: JAL and backward B-type are predicted taken.
// Only compiled when FETCH_STATIC_PREDICT_EN is defined.
`ifdef FETCH_STATIC_PREDICT_EN
module fetch_predecode
  import fetch_stage_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic        pred_taken_o,
  output logic [31:0] target_o
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] target;

  always_comb begin
    imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    pred_taken_o = 1'b0;
    target       = pc_i + 32'd4;
    if (inst_i[6:0] == OP_JAL) begin
      pred_taken_o = 1'b1;
      target       = pc_i + imm_j;
    end else if (inst_i[6:0] == OP_BRANCH && inst_i[31]) begin
      pred_taken_o = 1'b1;
      target       = pc_i + imm_b;
    end
    // Fetch PC stays word aligned even for a half-word target.
    target_o = target & ~32'd3;
  end

endmodule
`endif

// File: rtl/fetch_stage.sv
// Front-end fetch: one outstanding line request, streams up to NumSlots packets per cycle.
// Define FETCH_STATIC_PREDICT_EN to add per-slot static prediction via fetch_predecode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned LINE_INSTS = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           restore_valid,
  input  logic [31:0]                    restore_pc,
  input  logic [ScalarBits-1:0]          inst_buffer_spots,
  output logic                           icache_req_valid,
  output logic [31:0]                    icache_req_addr,
  input  logic                           icache_req_ready,
  input  logic                           icache_rsp_valid,
  input  logic [32*LINE_INSTS-1:0]       icache_rsp_line,
  output FETCH_PACKET [NumSlots-1:0]     inst_buffer_inputs,
  output logic [ScalarBits-1:0]          inst_valid
);

  localparam int unsigned OffBits  = $clog2(LINE_INSTS);
  localparam int unsigned LineBits = OffBits + 2;
  localparam logic [31:0] LineMask = ~(32'(4 * LINE_INSTS) - 32'd1);

  fetch_state_t            state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [32*LINE_INSTS-1:0] line_q, line_d;
  logic [31:0]             line_base_q, line_base_d;
  logic                    line_valid_q, line_valid_d;

  logic [OffBits-1:0]           off;
  logic [NumSlots-1:0][31:0]    slot_pc;
  logic [NumSlots-1:0][31:0]    slot_inst;
  logic [NumSlots-1:0][31:0]    slot_npc;
  logic [NumSlots-1:0]          slot_taken;
  int unsigned                  grp_len;

  assign off = pc_q[LineBits-1:2];

  for (genvar s = 0; s < NumSlots; s++) begin : g_slot
    logic [OffBits:0] idx;
    assign idx          = {1'b0, off} + (OffBits + 1)'(s);
    assign slot_pc[s]   = pc_q + 32'(4 * s);
    assign slot_inst[s] = (idx < (OffBits + 1)'(LINE_INSTS)) ?
                          line_q[32*idx[OffBits-1:0] +: 32] : '0;
`ifdef FETCH_STATIC_PREDICT_EN
    logic [31:0] target;
    fetch_predecode u_predecode (
      .inst_i       (slot_inst[s]),
      .pc_i         (slot_pc[s]),
      .pred_taken_o (slot_taken[s]),
      .target_o     (target)
    );
    assign slot_npc[s] = slot_taken[s] ? target : slot_pc[s] + 32'd4;
`else
    assign slot_taken[s] = 1'b0;
    assign slot_npc[s]   = slot_pc[s] + 32'd4;
`endif
  end

  // Group length: slot budget, buffer room, rest of line, then cut after first taken slot.
  always_comb begin
    grp_len = NumSlots;
    if (32'(inst_buffer_spots) < grp_len) grp_len = 32'(inst_buffer_spots);
    if (LINE_INSTS - 32'(off) < grp_len) grp_len = LINE_INSTS - 32'(off);
    for (int unsigned s = 0; s < NumSlots; s++) begin
      if (slot_taken[s] && s < grp_len) grp_len = s + 1;
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    line_d             = line_q;
    line_base_d        = line_base_q;
    line_valid_d       = line_valid_q;
    icache_req_valid   = 1'b0;
    icache_req_addr    = pc_q & LineMask;
    inst_valid         = '0;
    inst_buffer_inputs = '0;

    unique case (state_q)
      REQ: begin
        icache_req_valid = !restore_valid;
        if (icache_req_valid && icache_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (icache_rsp_valid) begin
          line_d       = icache_rsp_line;
          line_base_d  = pc_q & LineMask;
          line_valid_d = 1'b1;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (line_valid_q && grp_len != 0) begin
          for (int unsigned s = 0; s < NumSlots; s++) begin
            if (s < grp_len) begin
              inst_buffer_inputs[s] = '{inst: slot_inst[s], PC: slot_pc[s],
                                        NPC: slot_npc[s], pred_taken: slot_taken[s]};
              pc_d = slot_npc[s];
            end
          end
          inst_valid = ScalarBits'(grp_len);
          if ((pc_d & LineMask) != line_base_q) begin
            line_valid_d = 1'b0;
            state_d      = REQ;
          end
        end
      end
      DROP: begin
        if (icache_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    // Redirect wins; a request still in flight must have its response thrown away.
    if (restore_valid) begin
      inst_valid         = '0;
      inst_buffer_inputs = '0;
      pc_d               = restore_pc;
      line_valid_d       = 1'b0;
      state_d            = ((state_q == WAIT || state_q == DROP) && !icache_rsp_valid) ?
                           DROP : REQ;
    end

    if (reset) begin
      icache_req_valid   = 1'b0;
      inst_valid         = '0;
      inst_buffer_inputs = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      line_q       <= '0;
      line_base_q  <= '0;
      line_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      line_q       <= line_d;
      line_base_q  <= line_base_d;
      line_valid_q <= line_valid_d;
    end
  end

endmodule
